layer_one_frame_server: RTL and testbench

Frame buffer and sequencer in front of the second hidden layer controller. It collects one frame of first-layer activations (NUM_PIXELS 32-bit words) from an upstream valid/ready stream, then asserts a level start to the second-layer controller. While that controller runs, the block serves activations by index. When the controller reports done, the block captures its NUM_OUT results, drops start, waits for done to fall, and re-arms for the next frame.

---
 rtl/layer_one_frame_server.sv | 112 +++++++++++
 tb/tb_layer_one_frame_server.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_one_frame_server.sv
// Frame buffer and sequencer in front of the second-layer controller: fill a frame, start L2,
// capture its results on done, wait for done to fall, re-arm for the next frame.
module layer_one_frame_server #(
   parameter int NUM_PIXELS = 20,
   parameter int NUM_OUT    = 7,
   parameter int RELU_IN    = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [31:0]               in_data,
   output logic                      in_ready,
   input  logic [4:0]                layer_one_counter,
   output logic [31:0]               layer_one_out,
   output logic                      l2_start,
   input  logic                      l2_done,
   input  logic [NUM_OUT-1:0][31:0]  l2_result,
   output logic [NUM_OUT-1:0][31:0]  result,
   output logic                      result_valid,
   output logic [15:0]               frame_count
);

   localparam logic [4:0] NP   = 5'(NUM_PIXELS);
   localparam logic [4:0] LAST = 5'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {FILL, RUN, RELEASE} state_t;

   state_t                     state_q, state_d;
   logic [4:0]                 wr_ptr_q, wr_ptr_d;
   logic [31:0]                mem_q [NUM_PIXELS];
   logic [31:0]                mem_d [NUM_PIXELS];
   logic [NUM_OUT-1:0][31:0]   result_q, result_d;
   logic                       result_valid_q, result_valid_d;
   logic [15:0]                frame_count_q, frame_count_d;
   logic                       in_ready_q, in_ready_d;
   logic                       l2_start_q, l2_start_d;
   logic                       accept;
   logic [31:0]                wr_data;

   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      mem_d          = mem_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      frame_count_d  = frame_count_q;
      accept         = in_valid && in_ready_q;
      wr_data        = (RELU_IN != 0 && in_data[31]) ? 32'd0 : in_data;

      case (state_q)
         FILL: begin
            if (accept) begin
               mem_d[wr_ptr_q] = wr_data;
               if (wr_ptr_q == LAST) begin
                  wr_ptr_d = 5'd0;
                  state_d  = RUN;
               end else begin
                  wr_ptr_d = wr_ptr_q + 5'd1;
               end
            end
         end
         RUN: begin
            if (l2_done) begin
               result_d       = l2_result;
               result_valid_d = 1'b1;
               state_d        = RELEASE;
            end
         end
         RELEASE: begin
            if (!l2_done) begin
               frame_count_d = frame_count_q + 16'd1;
               state_d       = FILL;
            end
         end
         default: state_d = FILL;
      endcase

      // Handshake outputs are flops decoded from the next state so they never glitch.
      in_ready_d = (state_d == FILL);
      l2_start_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= FILL;
         wr_ptr_q       <= 5'd0;
         for (int i = 0; i < NUM_PIXELS; i++) mem_q[i] <= 32'd0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         frame_count_q  <= 16'd0;
         in_ready_q     <= 1'b1;
         l2_start_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         mem_q          <= mem_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         frame_count_q  <= frame_count_d;
         in_ready_q     <= in_ready_d;
         l2_start_q     <= l2_start_d;
      end
   end

   assign layer_one_out = (layer_one_counter < NP) ? mem_q[layer_one_counter] : 32'd0;
   assign in_ready      = in_ready_q;
   assign l2_start      = l2_start_q;
   assign result        = result_q;
   assign result_valid  = result_valid_q;
   assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_layer_one_frame_server.sv
// Randomized bench for layer_one_frame_server with a frame-level reference model;
// a RELU_IN=0 twin shares all inputs so clamped and unclamped storage can be compared.
module tb_layer_one_frame_server;

   localparam int NP = 20;
   localparam int NO = 7;

   logic                  clk = 1'b0;
   logic                  reset, in_valid, l2_done;
   logic [31:0]           in_data;
   logic [4:0]            layer_one_counter;
   logic [NO-1:0][31:0]   l2_result;

   logic                  in_ready, l2_start, result_valid;
   logic [31:0]           layer_one_out;
   logic [NO-1:0][31:0]   result;
   logic [15:0]           frame_count;

   logic                  in_ready0, l2_start0, result_valid0;
   logic [31:0]           layer_one_out0;
   logic [NO-1:0][31:0]   result0;
   logic [15:0]           frame_count0;

   layer_one_frame_server #(.NUM_PIXELS(NP), .NUM_OUT(NO), .RELU_IN(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .layer_one_counter(layer_one_counter), .layer_one_out(layer_one_out),
      .l2_start(l2_start), .l2_done(l2_done), .l2_result(l2_result),
      .result(result), .result_valid(result_valid), .frame_count(frame_count));

   layer_one_frame_server #(.NUM_PIXELS(NP), .NUM_OUT(NO), .RELU_IN(0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
      .layer_one_counter(layer_one_counter), .layer_one_out(layer_one_out0),
      .l2_start(l2_start0), .l2_done(l2_done), .l2_result(l2_result),
      .result(result0), .result_valid(result_valid0), .frame_count(frame_count0));

   always #5 clk = ~clk;

   int                    errors = 0;
   int                    checks = 0;
   logic [31:0]           exp_mem  [NP];
   logic [31:0]           exp_mem0 [NP];
   logic [NO-1:0][31:0]   exp_result;
   logic [15:0]           exp_fc;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NP; i++) begin
         exp_mem[i]  = 32'd0;
         exp_mem0[i] = 32'd0;
      end
      exp_result = '0;
      exp_fc     = 16'd0;
   endtask

   task automatic check_buffer(input string tag);
      for (int i = 0; i < 32; i++) begin
         logic [31:0] e, e0;
         e  = (i < NP) ? exp_mem[i]  : 32'd0;
         e0 = (i < NP) ? exp_mem0[i] : 32'd0;
         layer_one_counter = 5'(i);
         #1;
         checks++;
         if (layer_one_out !== e || layer_one_out0 !== e0) begin
            errors++;
            $display("FAIL %s read[%0d]: got %h/%h want %h/%h", tag, i,
                     layer_one_out, layer_one_out0, e, e0);
         end
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = $urandom;
      l2_done  = 1'b0;
      l2_result = '0;
      layer_one_counter = 5'd0;
      tick();
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      clear_model();
      checks++;
      if (in_ready !== 1'b1 || l2_start !== 1'b0 || result_valid !== 1'b0 ||
          frame_count !== 16'd0 || result !== exp_result) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b start=%b rv=%b fc=%0d res=%h want 1 0 0 0 0",
                  in_ready, l2_start, result_valid, frame_count, result);
      end
      foreach (exp_mem[i]) begin end
      for (int k = 0; k < 3; k++) begin
         layer_one_counter = (k == 0) ? 5'd0 : (k == 1) ? 5'd19 : 5'd31;
         #1;
         checks++;
         if (layer_one_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_read[%0d]: got %h want 0", layer_one_counter, layer_one_out);
         end
      end
   endtask

   // seq=1 streams 1..NP; otherwise random words. neg_idx forces a negative word at that index.
   task automatic test_fill(input bit seq, input int neg_idx, input string tag);
      int n = 0;
      int budget = 0;
      while (n < NP && budget < 2000) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = seq ? 32'(n + 1) : $urandom;
         if (n == neg_idx) in_data = 32'hFFFF_FFF0;
         checks++;
         if (in_ready !== 1'b1 || l2_start !== 1'b0) begin
            errors++;
            $display("FAIL %s fill_rdy n=%0d: rdy=%b start=%b want 1 0", tag, n, in_ready, l2_start);
         end
         tick();
         budget++;
         if (in_valid) begin
            exp_mem0[n] = in_data;
            exp_mem[n]  = in_data[31] ? 32'd0 : in_data;
            layer_one_counter = 5'(n);
            #1;
            checks++;
            if (layer_one_out !== exp_mem[n]) begin
               errors++;
               $display("FAIL %s accept_visible[%0d]: got %h want %h", tag, n, layer_one_out, exp_mem[n]);
            end
            n++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n != NP || in_ready !== 1'b0 || l2_start !== 1'b1 || in_ready0 !== 1'b0 || l2_start0 !== 1'b1) begin
         errors++;
         $display("FAIL %s fill_done: accepts=%0d rdy=%b start=%b want %0d 0 1", tag, n, in_ready, l2_start, NP);
      end
      check_buffer(tag);
   endtask

   task automatic test_relu();
      layer_one_counter = 5'd3;
      #1;
      checks++;
      if (layer_one_out !== 32'd0 || layer_one_out0 !== 32'hFFFF_FFF0) begin
         errors++;
         $display("FAIL relu_idx3: got %h/%h want 00000000/fffffff0", layer_one_out, layer_one_out0);
      end
   endtask

   // Waits `delay` cycles in RUN under junk traffic, then holds done for `hold` cycles.
   task automatic test_handshake(input int delay, input int hold, input bit pattern, input string tag);
      logic [NO-1:0][31:0] r;
      for (int i = 0; i < NO; i++) r[i] = pattern ? 32'(i + 'h100) : $urandom;
      in_valid = 1'b1;
      in_data  = 32'h0000_DEAD;
      for (int c = 0; c < delay; c++) begin
         tick();
         checks++;
         if (l2_start !== 1'b1 || in_ready !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s run_hold c=%0d: start=%b rdy=%b rv=%b want 1 0 0", tag, c, l2_start, in_ready, result_valid);
         end
      end
      l2_done   = 1'b1;
      l2_result = r;
      tick();
      exp_result = r;
      checks++;
      if (result !== exp_result || result_valid !== 1'b1 || l2_start !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s capture: res=%h rv=%b start=%b rdy=%b want %h 1 0 0",
                  tag, result, result_valid, l2_start, in_ready, exp_result);
      end
      l2_result = ~r;
      for (int c = 1; c < hold; c++) begin
         tick();
         checks++;
         if (result_valid !== 1'b0 || in_ready !== 1'b0 || result !== exp_result) begin
            errors++;
            $display("FAIL %s release_hold: rv=%b rdy=%b res=%h want 0 0 %h", tag, result_valid, in_ready, result, exp_result);
         end
      end
      l2_done = 1'b0;
      tick();
      in_valid = 1'b0;
      exp_fc = exp_fc + 16'd1;
      checks++;
      if (in_ready !== 1'b1 || frame_count !== exp_fc || result_valid !== 1'b0 ||
          l2_start !== 1'b0 || result !== exp_result) begin
         errors++;
         $display("FAIL %s rearm: rdy=%b fc=%0d rv=%b start=%b want 1 %0d 0 0",
                  tag, in_ready, frame_count, result_valid, l2_start, exp_fc);
      end
      check_buffer({tag, "_post"});
   endtask

   task automatic test_stale_done();
      for (int c = 0; c < 4; c++) begin
         l2_done   = 1'b1;
         l2_result = {NO{$urandom}};
         tick();
         checks++;
         if (result_valid !== 1'b0 || result !== exp_result || in_ready !== 1'b1 ||
             l2_start !== 1'b0 || frame_count !== exp_fc) begin
            errors++;
            $display("FAIL stale_done c=%0d: rv=%b res=%h rdy=%b start=%b fc=%0d", c,
                     result_valid, result, in_ready, l2_start, frame_count);
         end
      end
      l2_done = 1'b0;
      tick();
   endtask

   task automatic test_mid_reset();
      test_fill(1'b0, -1, "pre_reset");
      tick();
      tick();
      reset    = 1'b1;
      in_valid = 1'b1;
      l2_done  = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      l2_done  = 1'b0;
      clear_model();
      checks++;
      if (l2_start !== 1'b0 || in_ready !== 1'b1 || frame_count !== 16'd0 ||
          result !== exp_result || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: start=%b rdy=%b fc=%0d rv=%b want 0 1 0 0",
                  l2_start, in_ready, frame_count, result_valid);
      end
      check_buffer("mid_reset");
   endtask

   initial begin
      test_reset();
      test_fill(1'b1, -1, "fill_seq");
      test_handshake(300, 2, 1'b1, "hs_pattern");
      test_stale_done();
      test_fill(1'b0, 3, "fill_relu");
      test_relu();
      test_handshake($urandom_range(1, 40), 1, 1'b0, "hs_min_turn");
      test_fill(1'b0, -1, "back_to_back");
      test_handshake($urandom_range(1, 40), $urandom_range(1, 5), 1'b0, "hs_b2b");
      test_mid_reset();
      test_fill(1'b0, -1, "after_reset");
      test_handshake($urandom_range(1, 40), 2, 1'b0, "hs_after_reset");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
